// File: rtl/inst_cache_if.sv
// Fetch-side and memory-side signals of the instruction cache, bundled for one port.
// master = core + Instruction_memory side, slave = the cache.
interface inst_cache_if #(
  parameter int WIDTH = 32
);
  logic             rom_en;
  logic [WIDTH-1:0] rom_addr;
  logic [WIDTH-1:0] rom_data;
  logic             stall;
  logic             inv;
  logic             mem_en;
  logic [WIDTH-3:0] mem_addr;
  logic [WIDTH-1:0] mem_data;

  modport master (
    output rom_en, rom_addr, inv, mem_data,
    input  rom_data, stall, mem_en, mem_addr
  );

  modport slave (
    input  rom_en, rom_addr, inv, mem_data,
    output rom_data, stall, mem_en, mem_addr
  );
endinterface

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache, 4-word lines, refill from a synchronous memory.
// Latency: hit 1 cycle (registered rom_data); miss holds stall for 5 cycles then returns the word.
// Backpressure: stall freezes the core; fetch inputs are ignored while a refill is in flight.
module inst_cache #(
  parameter int WIDTH      = 32,
  parameter int INDEX_BITS = 4
) (
  input logic         clk,
  input logic         rst,
  inst_cache_if.slave bus
);
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = WIDTH - 4 - INDEX_BITS;

  typedef enum logic {IDLE, FILL} state_t;

  state_t                state_q, state_d;
  logic [2:0]            cnt_q;
  logic [WIDTH-3:0]      miss_addr_q;
  logic                  inv_pend_q;
  logic [LINES-1:0]      valid_q;
  logic [WIDTH-1:0]      rom_data_q;
  logic                  stall_q;
  logic [TAG_BITS-1:0]   tag_q  [LINES];
  logic [WIDTH-1:0]      data_q [LINES][4];

  logic [1:0]            req_off;
  logic [INDEX_BITS-1:0] req_idx;
  logic [TAG_BITS-1:0]   req_tag;
  logic [1:0]            miss_off;
  logic [INDEX_BITS-1:0] miss_idx;
  logic [TAG_BITS-1:0]   miss_tag;
  logic [1:0]            fill_word;
  logic                  hit;
  logic                  start_fill;
  logic                  finish;
  logic                  unused_addr_bits;

  assign req_off  = bus.rom_addr[3:2];
  assign req_idx  = bus.rom_addr[3+INDEX_BITS:4];
  assign req_tag  = bus.rom_addr[WIDTH-1:4+INDEX_BITS];
  assign miss_off = miss_addr_q[1:0];
  assign miss_idx = miss_addr_q[1+INDEX_BITS:2];
  assign miss_tag = miss_addr_q[WIDTH-3:2+INDEX_BITS];
  // Memory data lags its address by one cycle, so count n lands in word n-1.
  assign fill_word = cnt_q[1:0] - 2'd1;
  assign unused_addr_bits = ^bus.rom_addr[1:0];

  // An invalidate in the same cycle wins over the lookup.
  assign hit = bus.rom_en && valid_q[req_idx] && (tag_q[req_idx] == req_tag) && !bus.inv;

  assign bus.mem_en   = (state_q == FILL) && !cnt_q[2];
  assign bus.mem_addr = {miss_addr_q[WIDTH-3:2], cnt_q[1:0]};
  assign bus.rom_data = rom_data_q;
  assign bus.stall    = stall_q;

  always_comb begin
    state_d    = state_q;
    start_fill = 1'b0;
    finish     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.rom_en && !hit) begin
          state_d    = FILL;
          start_fill = 1'b1;
        end
      end
      FILL: begin
        if (cnt_q == 3'd4) begin
          state_d = IDLE;
          finish  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      miss_addr_q <= '0;
      inv_pend_q  <= 1'b0;
      valid_q     <= '0;
      rom_data_q  <= '0;
      stall_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        if (hit) begin
          rom_data_q <= data_q[req_idx][req_off];
        end else if (start_fill) begin
          miss_addr_q <= bus.rom_addr[WIDTH-1:2];
          cnt_q       <= 3'd0;
          stall_q     <= 1'b1;
        end
        if (bus.inv) begin
          valid_q <= '0;
        end
      end else begin
        cnt_q <= cnt_q + 3'd1;
        if (bus.inv) begin
          inv_pend_q <= 1'b1;
        end
        if (finish) begin
          // Word 3 is only just arriving, so bypass it from memory.
          rom_data_q <= (miss_off == 2'd3) ? bus.mem_data : data_q[miss_idx][miss_off];
          stall_q    <= 1'b0;
          cnt_q      <= 3'd0;
          inv_pend_q <= 1'b0;
          if (inv_pend_q || bus.inv) begin
            valid_q <= '0;
          end else begin
            valid_q[miss_idx] <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if ((state_q == FILL) && (cnt_q != 3'd0)) begin
      data_q[miss_idx][fill_word] <= bus.mem_data;
    end
    if (finish) begin
      tag_q[miss_idx] <= miss_tag;
    end
  end
endmodule
